// File: rtl/perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : perf_monitor
//  Description : Pipeline performance monitor. Counts run cycles, non-branch
//                stalls, IF/ID flushes and retired instructions while the CPU
//                is started, stopping after MAX_CYCLES counted cycles.
//                Counters saturate and never wrap. Any counter can be read
//                with a one-cycle request/valid handshake.
//  Parameters  : CNT_W       counter width in bits
//                MAX_CYCLES  counted cycles after which counting stops
//  Ports       : clk_i       clock, rising edge active
//                rst_i       asynchronous active-low reset
//                start_i     counting enabled while high
//                stall_i     hazard-unit stall request
//                branch_i    branch decoded in ID (its stalls are excluded)
//                flush_i     IF/ID flush
//                retire_i    instruction retiring with a write
//                clear_i     synchronous clear of counters and state
//                rd_req_i    read request pulse
//                rd_sel_i    0 cycle, 1 stall, 2 flush, 3 retire
//                rd_valid_o  read data valid pulse, one cycle after request
//                rd_data_o   selected counter value, 0 when not valid
//                done_o      high while MAX_CYCLES have been counted
//  Options     : PERF_SNAPSHOT_EN  when defined, counters are copied into
//                shadow registers on entry to DONE and reads return those
//  Revision    : 1.0  initial release
// ============================================================================
module perf_monitor #(
   parameter int CNT_W      = 32,
   parameter int MAX_CYCLES = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             stall_i,
   input  logic             branch_i,
   input  logic             flush_i,
   input  logic             retire_i,
   input  logic             clear_i,
   input  logic             rd_req_i,
   input  logic [1:0]       rd_sel_i,
   output logic             rd_valid_o,
   output logic [CNT_W-1:0] rd_data_o,
   output logic             done_o
);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_RUN  = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_CYCLES);
   // A limit beyond the counter's saturation value can never be hit; the
   // truncated compare value must then be ignored.
   localparam bit c_MAX_REACHABLE = (MAX_CYCLES > 0) &&
      (longint'(MAX_CYCLES) <= ((longint'(1) << CNT_W) - longint'(1)));

   logic [1:0]       r_state;
   logic [1:0]       w_state_next;
   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_stall;
   logic [CNT_W-1:0] r_flush;
   logic [CNT_W-1:0] r_retire;
   logic [CNT_W-1:0] w_cycle_next;
   logic [CNT_W-1:0] w_stall_next;
   logic [CNT_W-1:0] w_flush_next;
   logic [CNT_W-1:0] w_retire_next;
   logic [CNT_W-1:0] w_rd_val;
   logic             r_rd_valid;
   logic [CNT_W-1:0] r_rd_data;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic en);
      return (en && (v != '1)) ? (v + c_ONE) : v;
   endfunction

   // ------------------------------------------------------------------------
   // Next-state and counter update
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next  = r_state;
      w_cycle_next  = r_cycle;
      w_stall_next  = r_stall;
      w_flush_next  = r_flush;
      w_retire_next = r_retire;
      case (r_state)
         c_ST_IDLE: begin
            // The starting edge only arms the monitor; nothing is counted.
            if (start_i) begin
               w_state_next = c_ST_RUN;
            end
         end
         c_ST_RUN: begin
            if (!start_i) begin
               w_state_next = c_ST_IDLE;
            end else begin
               w_cycle_next  = sat_inc(r_cycle, 1'b1);
               w_stall_next  = sat_inc(r_stall, stall_i & ~branch_i);
               w_flush_next  = sat_inc(r_flush, flush_i);
               w_retire_next = sat_inc(r_retire, retire_i);
               if (c_MAX_REACHABLE && (w_cycle_next == c_MAX_CNT)) begin
                  w_state_next = c_ST_DONE;
               end
            end
         end
         c_ST_DONE: begin
            w_state_next = c_ST_DONE;
         end
         default: begin
            w_state_next = c_ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= c_ST_IDLE;
         r_cycle  <= '0;
         r_stall  <= '0;
         r_flush  <= '0;
         r_retire <= '0;
      end else if (clear_i) begin
         r_state  <= c_ST_IDLE;
         r_cycle  <= '0;
         r_stall  <= '0;
         r_flush  <= '0;
         r_retire <= '0;
      end else begin
         r_state  <= w_state_next;
         r_cycle  <= w_cycle_next;
         r_stall  <= w_stall_next;
         r_flush  <= w_flush_next;
         r_retire <= w_retire_next;
      end
   end

   // ------------------------------------------------------------------------
   // Read source: shadow copy or live counters
   // ------------------------------------------------------------------------
`ifdef PERF_SNAPSHOT_EN
   logic [CNT_W-1:0] r_sh_cycle;
   logic [CNT_W-1:0] r_sh_stall;
   logic [CNT_W-1:0] r_sh_flush;
   logic [CNT_W-1:0] r_sh_retire;
   logic             w_enter_done;

   // Capture the values as they will be after the edge that enters DONE.
   assign w_enter_done = (r_state == c_ST_RUN) && (w_state_next == c_ST_DONE);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_sh_cycle  <= '0;
         r_sh_stall  <= '0;
         r_sh_flush  <= '0;
         r_sh_retire <= '0;
      end else if (clear_i) begin
         r_sh_cycle  <= '0;
         r_sh_stall  <= '0;
         r_sh_flush  <= '0;
         r_sh_retire <= '0;
      end else if (w_enter_done) begin
         r_sh_cycle  <= w_cycle_next;
         r_sh_stall  <= w_stall_next;
         r_sh_flush  <= w_flush_next;
         r_sh_retire <= w_retire_next;
      end
   end

   always_comb begin
      w_rd_val = '0;
      case (rd_sel_i)
         2'd0:    w_rd_val = r_sh_cycle;
         2'd1:    w_rd_val = r_sh_stall;
         2'd2:    w_rd_val = r_sh_flush;
         default: w_rd_val = r_sh_retire;
      endcase
   end
`else
   always_comb begin
      w_rd_val = '0;
      case (rd_sel_i)
         2'd0:    w_rd_val = r_cycle;
         2'd1:    w_rd_val = r_stall;
         2'd2:    w_rd_val = r_flush;
         default: w_rd_val = r_retire;
      endcase
   end
`endif

   // ------------------------------------------------------------------------
   // Read response: registers hold pre-edge values, so a read coinciding
   // with an increment or a clear returns the value before that edge.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= rd_req_i;
         r_rd_data  <= rd_req_i ? w_rd_val : '0;
      end
   end

   assign rd_valid_o = r_rd_valid;
   assign rd_data_o  = r_rd_data;
   assign done_o     = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
